// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-stage inputs, forwarding sources and ID/EX register outputs
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
interface id_ex_stage_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic                    id_valid;
  logic [REG_ADDR_W-1:0]   id_src1;
  logic [REG_ADDR_W-1:0]   id_src2;
  logic                    id_uses_src2;
  logic [`WORD_SIZE-1:0]   id_rf_val1;
  logic [`WORD_SIZE-1:0]   id_rf_val2;
  logic [REG_ADDR_W-1:0]   id_dest;
  logic                    id_reg_write;
  logic                    id_mem_read;
  logic [`WORD_SIZE-1:0]   id_imm;
  logic [REG_ADDR_W-1:0]   exm_dest;
  logic                    exm_reg_write;
  logic                    exm_is_load;
  logic [`WORD_SIZE-1:0]   exm_result;
  logic [REG_ADDR_W-1:0]   wb_dest;
  logic                    wb_reg_write;
  logic [`WORD_SIZE-1:0]   wb_val;
  logic                    flush;
  logic                    stall;
  logic                    ex_valid;
  logic                    ex_reg_write;
  logic                    ex_mem_read;
  logic [`WORD_SIZE-1:0]   ex_op1;
  logic [`WORD_SIZE-1:0]   ex_op2;
  logic [`WORD_SIZE-1:0]   ex_imm;
  logic [REG_ADDR_W-1:0]   ex_dest;
  logic [STALL_CNT_W-1:0]  stall_cnt;
  modport master (
    output id_valid, id_src1, id_src2, id_uses_src2, id_rf_val1, id_rf_val2,
           id_dest, id_reg_write, id_mem_read, id_imm,
           exm_dest, exm_reg_write, exm_is_load, exm_result,
           wb_dest, wb_reg_write, wb_val, flush,
    input  stall, ex_valid, ex_reg_write, ex_mem_read, ex_op1, ex_op2, ex_imm,
           ex_dest, stall_cnt
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_uses_src2, id_rf_val1, id_rf_val2,
           id_dest, id_reg_write, id_mem_read, id_imm,
           exm_dest, exm_reg_write, exm_is_load, exm_result,
           wb_dest, wb_reg_write, wb_val, flush,
    output stall, ex_valid, ex_reg_write, ex_mem_read, ex_op1, ex_op2, ex_imm,
           ex_dest, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: operand forwarding, load/ALU hazard stall and ID/EX pipeline register
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
module id_ex_stage #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);
  logic                   r_ex_valid;
  logic                   r_ex_reg_write;
  logic                   r_ex_mem_read;
  logic [`WORD_SIZE-1:0]  r_ex_op1;
  logic [`WORD_SIZE-1:0]  r_ex_op2;
  logic [`WORD_SIZE-1:0]  r_ex_imm;
  logic [REG_ADDR_W-1:0]  r_ex_dest;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_live1;
  logic                   w_live2;
  logic                   w_haz1;
  logic                   w_haz2;
  logic                   w_stall;
  logic                   w_bubble;
  logic [`WORD_SIZE-1:0]  w_op1;
  logic [`WORD_SIZE-1:0]  w_op2;
  function automatic logic hazard(input logic live, input logic [REG_ADDR_W-1:0] src,
                                  input logic ex_v, input logic ex_rw,
                                  input logic [REG_ADDR_W-1:0] ex_d,
                                  input logic exm_rw, input logic exm_ld,
                                  input logic [REG_ADDR_W-1:0] exm_d);
    return live && ((ex_v && ex_rw && ex_d == src) || (exm_rw && exm_ld && exm_d == src));
  endfunction
  // EX/MEM beats MEM/WB; the MEM/WB bypass covers the same-edge reg_file write
  function automatic logic [`WORD_SIZE-1:0] resolve(input logic [REG_ADDR_W-1:0] src,
                                                     input logic [`WORD_SIZE-1:0] rf,
                                                     input logic exm_rw, input logic exm_ld,
                                                     input logic [REG_ADDR_W-1:0] exm_d,
                                                     input logic [`WORD_SIZE-1:0] exm_r,
                                                     input logic wb_rw,
                                                     input logic [REG_ADDR_W-1:0] wb_d,
                                                     input logic [`WORD_SIZE-1:0] wb_v);
    return (src == '0) ? '0 :
           (exm_rw && !exm_ld && exm_d == src) ? exm_r :
           (wb_rw && wb_d == src) ? wb_v : rf;
  endfunction
  always_comb begin
    w_live1  = bus.id_valid && bus.id_src1 != '0;
    w_live2  = bus.id_valid && bus.id_src2 != '0 && bus.id_uses_src2;
    w_haz1   = hazard(w_live1, bus.id_src1, r_ex_valid, r_ex_reg_write, r_ex_dest,
                      bus.exm_reg_write, bus.exm_is_load, bus.exm_dest);
    w_haz2   = hazard(w_live2, bus.id_src2, r_ex_valid, r_ex_reg_write, r_ex_dest,
                      bus.exm_reg_write, bus.exm_is_load, bus.exm_dest);
    w_stall  = (w_haz1 || w_haz2) && !bus.flush;
    w_bubble = bus.flush || w_stall || !bus.id_valid;
    w_op1    = resolve(bus.id_src1, bus.id_rf_val1, bus.exm_reg_write, bus.exm_is_load,
                       bus.exm_dest, bus.exm_result, bus.wb_reg_write, bus.wb_dest, bus.wb_val);
    w_op2    = resolve(bus.id_src2, bus.id_rf_val2, bus.exm_reg_write, bus.exm_is_load,
                       bus.exm_dest, bus.exm_result, bus.wb_reg_write, bus.wb_dest, bus.wb_val);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_op1       <= '0;
      r_ex_op2       <= '0;
      r_ex_imm       <= '0;
      r_ex_dest      <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      r_ex_valid     <= !w_bubble;
      r_ex_reg_write <= !w_bubble && bus.id_reg_write;
      r_ex_mem_read  <= !w_bubble && bus.id_mem_read;
      if (!w_bubble) begin
        r_ex_op1  <= w_op1;
        r_ex_op2  <= w_op2;
        r_ex_imm  <= bus.id_imm;
        r_ex_dest <= bus.id_dest;
      end
    end
  end
  assign bus.stall        = w_stall;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_reg_write = r_ex_reg_write;
  assign bus.ex_mem_read  = r_ex_mem_read;
  assign bus.ex_op1       = r_ex_op1;
  assign bus.ex_op2       = r_ex_op2;
  assign bus.ex_imm       = r_ex_imm;
  assign bus.ex_dest      = r_ex_dest;
  assign bus.stall_cnt    = r_stall_cnt;
endmodule
